// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// the x0 register index and the default dmem timeout.
package riscv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_ERROR    = 2'd3
   } hz_state_e;

   localparam logic [4:0] REG_X0          = 5'd0;
   localparam int         MEM_TIMEOUT_DEF = 256;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and flush-event performance counters for the hazard sequencer.
// Both counters wrap modulo 2^CNT_W and clear on asynchronous reset.
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_events_o
);

   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Count stalled cycles and acted-on redirects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_i) stall_q <= stall_q + 1'b1;
         if (flush_i) flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cycles_o = stall_q;
   assign flush_events_o = flush_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use,
// EX redirect, outstanding fetch and dmem wait hazards into stage-register
// enables/flushes, drains a stale fetch after a redirect and latches a sticky
// error when the data memory stops answering.
// Optional feature: define HAZARD_PERF_EN to build the perf counters;
// otherwise stall_cycles/flush_events are tied to zero.
module pipeline_hazard_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_redirect,
   input  logic             if_req,
   input  logic             if_ack,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic             pc_sel_redirect,
   output logic             if_squash,
   output logic             hazard_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int            TW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT - 1);

   hz_state_e     state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          load_use, mem_wait, if_wait;

   assign load_use = ex_memread && (ex_rd != REG_X0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
   assign mem_wait = dmem_req & ~dmem_ack;
   assign if_wait  = if_req & ~if_ack;

   assign hazard_err = (state_q == ST_ERROR);

   // State and dmem timeout counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Next state: a dmem wait freezes everything and ages the timeout; a
   // pending stale fetch exits DRAIN only when its response arrives.
   always_comb begin
      state_d = state_q;
      tcnt_d  = '0;
      if (state_q != ST_ERROR) begin
         if (mem_wait) begin
            if (tcnt_q == TMAX) begin
               state_d = ST_ERROR;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
               if (state_q == ST_DRAIN) state_d = if_ack ? ST_RUN : ST_DRAIN;
               else                     state_d = ST_MEM_WAIT;
            end
         end else if (state_q == ST_DRAIN) begin
            state_d = if_ack ? ST_RUN : ST_DRAIN;
         end else if (ex_redirect && if_wait) begin
            state_d = ST_DRAIN;
         end else begin
            state_d = ST_RUN;
         end
      end
   end

   // Same-cycle stage controls from state and hazard inputs.
   always_comb begin
      pc_en           = 1'b1;
      ifid_en         = 1'b1;
      idex_en         = 1'b1;
      exmem_en        = 1'b1;
      ifid_flush      = 1'b0;
      idex_flush      = 1'b0;
      memwb_flush     = 1'b0;
      pc_sel_redirect = 1'b0;
      if_squash       = 1'b0;
      if (!rst_n || (state_q == ST_ERROR)) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (mem_wait) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
         if_squash   = (state_q == ST_DRAIN);
      end else if (ex_redirect) begin
         pc_sel_redirect = 1'b1;
         ifid_flush      = 1'b1;
         idex_flush      = 1'b1;
         if_squash       = (state_q == ST_DRAIN);
      end else if (state_q == ST_DRAIN) begin
         if_squash = 1'b1;
         pc_en     = 1'b0;
         if (load_use) begin
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else begin
            ifid_flush = 1'b1;
         end
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (if_wait) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   hazard_perf_cnt #(
      .CNT_W(CNT_W)
   ) u_perf (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_i        (~pc_en && (state_q != ST_ERROR)),
      .flush_i        (pc_sel_redirect),
      .stall_cycles_o (stall_cycles),
      .flush_events_o (flush_events)
   );
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule
